// File: rtl/sram_bus_arbiter.sv
// Serialises the core's instruction-fetch and data requests onto one addr_ok/data_ok SRAM-like bus.
// Optional one-entry store buffer when DATA_WBUF_EN is defined.
module sram_bus_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_en,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_en,
    input  logic [3:0]        data_wen,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              stallreq,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_wstrb,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata
);

    typedef enum logic [2:0] {StIdle, StDReq, StDWait, StIReq, StIWait, StDone} state_e;

    state_e            state_q, state_d;
    logic              inst_pend_q, inst_pend_d;
    logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
    logic [DATA_W-1:0] data_rdata_q, data_rdata_d;

    // Source of the data-side transaction: the core, or the store buffer while draining.
    logic [3:0]        d_wen;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;

    function automatic logic [1:0] size_of(input logic [3:0] wen);
        case (wen)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: return 2'd0;
            4'b0011, 4'b1100:                   return 2'd1;
            default:                            return 2'd2;
        endcase
    endfunction

`ifdef DATA_WBUF_EN
    logic              buf_valid_q, buf_valid_d;
    logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
    logic [3:0]        buf_wstrb_q, buf_wstrb_d;
    logic [DATA_W-1:0] buf_wdata_q, buf_wdata_d;
    logic              drain_q, drain_d;

    assign d_wen   = drain_q ? buf_wstrb_q : data_wen;
    assign d_addr  = drain_q ? buf_addr_q  : data_addr;
    assign d_wdata = drain_q ? buf_wdata_q : data_wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_wstrb_q <= '0;
            buf_wdata_q <= '0;
            drain_q     <= 1'b0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_wstrb_q <= buf_wstrb_d;
            buf_wdata_q <= buf_wdata_d;
            drain_q     <= drain_d;
        end
    end
`else
    assign d_wen   = data_wen;
    assign d_addr  = data_addr;
    assign d_wdata = data_wdata;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            inst_pend_q  <= 1'b0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            inst_pend_q  <= inst_pend_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        inst_pend_d  = inst_pend_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        bus_req      = 1'b0;
        bus_wr       = 1'b0;
        bus_size     = 2'd0;
        bus_addr     = '0;
        bus_wstrb    = 4'b0000;
        bus_wdata    = '0;
`ifdef DATA_WBUF_EN
        buf_valid_d  = buf_valid_q;
        buf_addr_d   = buf_addr_q;
        buf_wstrb_d  = buf_wstrb_q;
        buf_wdata_d  = buf_wdata_q;
        drain_d      = drain_q;
`endif
        unique case (state_q)
            StIdle: begin
`ifdef DATA_WBUF_EN
                // Draining ahead of everything also makes a load that hits the buffer wait.
                if (buf_valid_q) begin
                    drain_d = 1'b1;
                    state_d = StDReq;
                end else if (data_en && (data_wen != 4'b0000)) begin
                    buf_valid_d = 1'b1;
                    buf_addr_d  = data_addr;
                    buf_wstrb_d = data_wen;
                    buf_wdata_d = data_wdata;
                    state_d     = inst_en ? StIReq : StDone;
                end else
`endif
                if (data_en) begin
                    state_d     = StDReq;
                    inst_pend_d = inst_en;
                end else if (inst_en) begin
                    state_d = StIReq;
                end
            end
            StDReq: begin
                bus_req   = 1'b1;
                bus_wr    = |d_wen;
                bus_size  = size_of(d_wen);
                bus_addr  = d_addr;
                bus_wstrb = d_wen;
                bus_wdata = d_wdata;
                if (bus_addr_ok) state_d = StDWait;
            end
            StDWait: begin
                if (bus_data_ok) begin
                    if (d_wen == 4'b0000) data_rdata_d = bus_rdata;
`ifdef DATA_WBUF_EN
                    if (drain_q) begin
                        drain_d     = 1'b0;
                        buf_valid_d = 1'b0;
                        state_d     = StIdle;
                    end else
`endif
                    if (inst_pend_q) begin
                        inst_pend_d = 1'b0;
                        state_d     = StIReq;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StIReq: begin
                bus_req  = 1'b1;
                bus_size = 2'd2;
                bus_addr = inst_addr;
                if (bus_addr_ok) state_d = StIWait;
            end
            StIWait: begin
                if (bus_data_ok) begin
                    inst_rdata_d = bus_rdata;
                    state_d      = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign stallreq   = (inst_en | data_en) & (state_q != StDone);
    assign inst_rdata = inst_rdata_q;
    assign data_rdata = data_rdata_q;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed and randomized bench for sram_bus_arbiter with a bus slave and a transaction-level
// reference model (expected bus transactions, stall length and returned words).
module tb_sram_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_en = 1'b0;
    logic [31:0] inst_addr = '0;
    logic [31:0] inst_rdata;
    logic        data_en = 1'b0;
    logic [3:0]  data_wen = '0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic [31:0] data_rdata;
    logic        stallreq;
    logic        bus_req, bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok = 1'b0;
    logic        bus_data_ok = 1'b0;
    logic [31:0] bus_rdata = '0;

    sram_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .inst_en(inst_en), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
        .data_en(data_en), .data_wen(data_wen), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata), .stallreq(stallreq),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
        .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
        .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } txn_t;

    int unsigned checks = 0;
    int unsigned errors = 0;
    txn_t        exp_q[$];
    logic [31:0] mem [logic [29:0]];
    logic [31:0] exp_inst_rdata = '0;
    logic [31:0] exp_data_rdata = '0;

    // Bus slave state
    int          a_dly = 0, d_dly = 0, req_wait = 0, resp_cnt = 0, n_txn = 0;
    bit          req_seen = 1'b0;
    txn_t        cur;
    logic [31:0] resp_data = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a[31:2])) return mem[a[31:2]];
        return {a[31:2], 2'b00} ^ 32'hC0DE_1234;
    endfunction

    task automatic mem_wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        logic [31:0] v;
        v = mem_rd(a);
        for (int b = 0; b < 4; b++) if (s[b]) v[b*8 +: 8] = d[b*8 +: 8];
        mem[a[31:2]] = v;
    endtask

    function automatic logic [1:0] exp_size(input logic [3:0] wen);
        if ($countones(wen) == 1) return 2'd0;
        if (wen == 4'b0011 || wen == 4'b1100) return 2'd1;
        return 2'd2;
    endfunction

    // One cycle of the bus slave, called at negedge+1 while outputs are settled.
    task automatic bus_cycle();
        txn_t e;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                bus_data_ok = 1'b1;
                bus_rdata   = resp_data;
            end
        end
        if (bus_req) begin
            if (!req_seen) begin
                req_seen = 1'b1;
                req_wait = 0;
                cur = '{wr: bus_wr, size: bus_size, addr: bus_addr, wstrb: bus_wstrb,
                        wdata: bus_wdata};
                n_txn++;
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("txn_wr", bus_wr, e.wr);
                    check("txn_size", bus_size, e.size);
                    check("txn_addr", bus_addr, e.addr);
                    check("txn_wstrb", bus_wstrb, e.wstrb);
                    if (e.wr) check("txn_wdata", bus_wdata, e.wdata);
                end
            end else begin
                check("hold_ctl", {bus_wr, bus_size, bus_wstrb, bus_addr},
                      {cur.wr, cur.size, cur.wstrb, cur.addr});
                check("hold_wdata", bus_wdata, cur.wdata);
            end
            if (req_wait == a_dly) begin
                bus_addr_ok = 1'b1;
                req_seen    = 1'b0;
                if (cur.wr) begin
                    mem_wr(cur.addr, cur.wstrb, cur.wdata);
                    resp_data = $urandom;
                end else begin
                    resp_data = mem_rd(cur.addr);
                end
                resp_cnt = d_dly + 1;
            end else begin
                req_wait++;
            end
        end
    endtask

    // Presents one request set, plays the bus until DONE and checks against the model.
    task automatic run_txn(input bit ie, input logic [31:0] ia, input bit de,
                           input logic [3:0] wen, input logic [31:0] da, input logic [31:0] wd,
                           input int ad, input int dd, input int extra, input string tag);
        int   n_exp, exp_stall, stall;
        txn_t t;
        a_dly = ad;
        d_dly = dd;
        n_txn = 0;
        if (de) begin
            t = '{wr: (wen != 4'b0000), size: exp_size(wen), addr: da, wstrb: wen, wdata: wd};
            exp_q.push_back(t);
            if (wen == 4'b0000) exp_data_rdata = mem_rd(da);
        end
        if (ie) begin
            t = '{wr: 1'b0, size: 2'd2, addr: ia, wstrb: 4'b0000, wdata: 32'h0};
            exp_q.push_back(t);
            exp_inst_rdata = mem_rd(ia);
        end
        n_exp     = exp_q.size();
        exp_stall = 1 + n_exp * (ad + dd + 2) + extra;
        @(negedge clk);
        inst_en = ie; inst_addr = ia;
        data_en = de; data_wen = wen; data_addr = da; data_wdata = wd;
        stall = 0;
        for (int c = 0; c < 200; c++) begin
            #1;
            if (!stallreq) break;
            stall++;
            bus_cycle();
            @(negedge clk);
        end
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        check({tag, "_stall"}, stall, exp_stall);
        check({tag, "_ntxn"}, n_txn, n_exp);
        check({tag, "_inst_rdata"}, inst_rdata, exp_inst_rdata);
        check({tag, "_data_rdata"}, data_rdata, exp_data_rdata);
        exp_q.delete();
        // DONE lasts one cycle: requests still held are seen as stalled again in IDLE.
        @(negedge clk);
        #1;
        check({tag, "_done_1cyc"}, stallreq, 1'b1);
        check({tag, "_idle_noreq"}, bus_req, 1'b0);
        inst_en = 1'b0;
        data_en = 1'b0;
        #1;
        check({tag, "_idle_stall"}, stallreq, 1'b0);
    endtask

    logic [3:0] wen_tab [9];

    initial begin
        wen_tab = '{4'b0000, 4'b0000, 4'b1111, 4'b0011, 4'b1100,
                    4'b0001, 4'b0010, 4'b0100, 4'b1000};

        #3 rst = 1'b0;
        #1;
        check("rst_stall", stallreq, 1'b0);
        check("rst_bus_ctl", {bus_req, bus_wr, bus_size, bus_wstrb}, 8'h00);
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_bus_wdata", bus_wdata, 32'h0);
        check("rst_inst_rdata", inst_rdata, 32'h0);
        check("rst_data_rdata", data_rdata, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        mem[30'h2FF0_0000] = 32'h2408_0001;
        run_txn(1'b1, 32'hBFC0_0000, 1'b0, 4'h0, 32'h0, 32'h0, 0, 0, 0, "inst");

        mem[30'h2000_0004] = 32'h1111_2222;
        mem[30'h2FF0_0001] = 32'h3333_4444;
        run_txn(1'b1, 32'hBFC0_0004, 1'b1, 4'h0, 32'h8000_0010, 32'h0, 0, 0, 0, "ld_if");

`ifndef DATA_WBUF_EN
        run_txn(1'b0, 32'h0, 1'b1, 4'b0010, 32'h8000_0001, 32'h0000_AB00, 0, 0, 0, "st_byte");
`endif

        run_txn(1'b0, 32'h0, 1'b1, 4'h0, 32'h8000_0008, 32'h0, 3, 2, 0, "slow_ld");

        // Reset while a load waits for data_ok; a late data_ok must be dropped.
        @(negedge clk);
        a_dly = 0; d_dly = 5; n_txn = 0;
        data_en = 1'b1; data_wen = 4'h0; data_addr = 32'h8000_0040;
        for (int c = 0; c < 3; c++) begin
            #1;
            bus_cycle();
            @(negedge clk);
        end
        #1;
        rst = 1'b0;
        data_en = 1'b0;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        resp_cnt = 0;
        req_seen = 1'b0;
        exp_data_rdata = '0;
        exp_inst_rdata = '0;
        #1;
        check("midrst_bus_req", bus_req, 1'b0);
        check("midrst_stall", stallreq, 1'b0);
        check("midrst_data_rdata", data_rdata, 32'h0);
        check("midrst_inst_rdata", inst_rdata, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bus_data_ok = 1'b1;
        bus_rdata   = 32'h1234_5678;
        @(negedge clk);
        bus_data_ok = 1'b0;
        #1;
        check("late_dok_data_rdata", data_rdata, 32'h0);
        check("late_dok_bus_req", bus_req, 1'b0);

        run_txn(1'b1, 32'hBFC0_0010, 1'b0, 4'h0, 32'h0, 32'h0, 1, 1, 0, "post_rst");

        for (int i = 0; i < 24; i++) begin
            bit          ie, de;
            logic [3:0]  wen;
            logic [31:0] da, ia, wd;
            int          sel;
            sel = $urandom_range(1, 3);
            ie  = sel[0];
            de  = sel[1];
            wen = wen_tab[$urandom_range(0, 8)];
`ifdef DATA_WBUF_EN
            wen = 4'b0000;
`endif
            da  = 32'h8000_0000 | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            ia  = 32'hBFC0_0000 | ($urandom_range(0, 63) << 2);
            wd  = $urandom;
            run_txn(ie, ia, de, wen, da, wd, $urandom_range(0, 3), $urandom_range(0, 3), 0,
                    "rand");
        end

`ifdef DATA_WBUF_EN
        // Store is absorbed by the buffer; a following load to it waits for the drain.
        @(negedge clk);
        a_dly = 0; d_dly = 0; n_txn = 0;
        data_en = 1'b1; data_wen = 4'hF; data_addr = 32'h8000_0020; data_wdata = 32'hCAFE_F00D;
        #1;
        check("wbuf_st_stall", stallreq, 1'b1);
        bus_cycle();
        @(negedge clk);
        #1;
        check("wbuf_st_done", stallreq, 1'b0);
        check("wbuf_st_nobus", n_txn, 0);
        data_en = 1'b0;
        mem_wr(32'h8000_0020, 4'hF, 32'hCAFE_F00D);
        exp_q.push_back('{wr: 1'b1, size: 2'd2, addr: 32'h8000_0020, wstrb: 4'hF,
                          wdata: 32'hCAFE_F00D});
        run_txn(1'b0, 32'h0, 1'b1, 4'h0, 32'h8000_0020, 32'h0, 0, 0, 1, "wbuf_ld");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
